uart_tx_queue: RTL
==================

// Module: uart_tx_queue
// PURPOSE
//  Byte FIFO plus send sequencer sitting directly upstream of the UART transmitter.
//  - CPU/MMIO side pushes bytes at core clock rate.
//  - Block presents one byte at a time on UART TX_data/TX_enable and holds it stable for the whole frame.
//  - Pops the byte only on UART byte_done; reports fill level and a sticky overflow flag to software.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >=2
//  ADDR_W   4  log2(DEPTH); count width is ADDR_W+1
// PORTS
//  clk           in   1        core clock; all logic on posedge
//  rst_n         in   1        synchronous, active-low reset
//  wr_en         in   1        push strobe, one byte per cycle
//  wr_data       in   8        byte to push
//  flush         in   1        discard all queued bytes not yet presented
//  clr_overflow  in   1        clears overflow flag
//  byte_done     in   1        from UART: frame complete (stop bit issued)
//  tx_enable     out  1        to UART TX_enable: byte on tx_data is ready to send
//  tx_data       out  8        to UART TX_data: held constant while tx_enable or in S_SEND
//  full          out  1        count == DEPTH
//  empty         out  1        count == 0
//  count         out  ADDR_W+1 bytes queued, including the byte in flight
//  busy          out  1        state != S_IDLE
//  overflow      out  1        sticky: a push was dropped
// BEHAVIOUR
//  Reset (rst_n=0 at posedge)
//  - ptrs=0, count=0, state=S_IDLE, tx_enable=0, tx_data=8'h00, overflow=0.
//  - UART shares rst_n; no handshake state survives reset.
//  Push
//  - Accepted iff wr_en && !full; writes mem[wr_ptr]; wr_ptr wraps DEPTH-1 -> 0.
//  - wr_en && full: byte dropped, overflow<=1.
//  - Same-cycle push and pop (not full): both happen, count unchanged.
//  - clr_overflow concurrent with a dropped push: set wins.
//  FSM (2 states)
//  - S_IDLE: if !empty && !flush: tx_data<=mem[rd_ptr], tx_enable<=1, ->S_SEND.
//  - S_SEND: hold tx_data. On byte_done: tx_enable<=0, rd_ptr++ (wrap), count--, ->S_IDLE.
//  - byte_done seen in S_IDLE is ignored.
//  Timing
//  - Push into empty FIFO at edge N: tx_enable=1 after edge N+1.
//  - Back-to-back bytes: tx_enable low exactly 1 cycle after byte_done, then high again.
//  - This gap is below one baud period (28 clk), so UART sees a continuous stream and never resends a byte.
//  Flush
//  - S_IDLE: ptrs and count cleared next edge.
//  - S_SEND: the in-flight byte cannot be aborted (UART has no abort). Queue is cleared except that byte:
//    wr_ptr<=rd_ptr+1, count<=1. Completion is then normal.
//  - flush+wr_en same cycle: flush applied, push dropped, overflow unchanged.
//  Width rules: count is ADDR_W+1 bits and never exceeds DEPTH; pointers are ADDR_W bits with natural wrap.
// STRUCTURE
//  - uart_defs.vh (shared with UART): BAUD_MAX_COUNT=28, S_IDLE/S_SEND encodings, byte width 8.
//  - Sub-module sync_fifo_mem (DEPTH x 8, 1W/1R, registered write, combinational read).
//    Pointers, count and FSM stay in uart_tx_queue.
// TESTING
//  1 Reset then idle 100 cycles -> tx_enable=0, empty=1, count=0, overflow=0.
//  2 Push 8'hA5 into empty queue, UART model -> tx_enable high 2 edges after push;
//    TX line shows 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop); count 1->0 on byte_done.
//  3 Push 8'h01,8'h02,8'h03 back-to-back -> three frames in order; tx_data stable throughout each frame;
//    tx_enable low exactly 1 cycle between frames.
//  4 Push 17 bytes with DEPTH=16 while UART stalled -> full=1, count=16, overflow=1, 17th byte absent;
//    clr_overflow -> overflow=0.
//  5 Queue 5 bytes, flush during first frame -> first byte completes, count=1 then 0, no further frames.
//  6 Assert rst_n=0 mid-frame on byte 8'h3C, push 8'h55 after release -> only 8'h55 transmitted, count correct.

Source files
------------

// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue: byte/frame geometry and
// the two-state send sequencer encoding used by the queue and the UART.
package uart_tx_queue_pkg;

    localparam int BYTE_W         = 8;
    localparam int BAUD_MAX_COUNT = 28;
    localparam int FRAME_BITS     = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/uart_tx_queue_mem.sv
// Byte storage for the transmit queue: one registered write port and one
// combinational read port, so the head byte is visible the cycle it is addressed.
module uart_tx_queue_mem
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem_r [DEPTH];

    // Write port; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte FIFO and send sequencer feeding the UART: presents the head byte on
// tx_data/tx_enable for a whole frame and pops it only on byte_done.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              flush,
    input  logic              clr_overflow,
    input  logic              byte_done,
    output logic              tx_enable,
    output logic [7:0]        tx_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1'b1);
    localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};

    tx_state_t         state_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W-1:0] wr_ptr_nxt_s;
    logic [ADDR_W-1:0] rd_ptr_nxt_s;
    logic [ADDR_W:0]   count_nxt_s;
    logic              overflow_nxt_s;
    logic              push_s;
    logic              pop_s;
    logic [7:0]        rd_data_s;

    uart_tx_queue_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    // Next pointer/count/overflow; flush during a frame keeps only the in-flight byte.
    always_comb begin
        push_s         = wr_en && !full && !flush;
        pop_s          = (state_r == S_SEND) && byte_done;
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        count_nxt_s    = count;
        overflow_nxt_s = overflow;

        if (flush) begin
            if (state_r == S_SEND) begin
                wr_ptr_nxt_s = rd_ptr_r + PTR_ONE;
                if (pop_s) begin
                    rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
                    count_nxt_s  = CNT_ZERO;
                end else begin
                    count_nxt_s  = CNT_ONE;
                end
            end else begin
                wr_ptr_nxt_s = PTR_ZERO;
                rd_ptr_nxt_s = PTR_ZERO;
                count_nxt_s  = CNT_ZERO;
            end
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count + CNT_ONE;
                2'b01:   count_nxt_s = count - CNT_ONE;
                default: count_nxt_s = count;
            endcase
        end

        if (wr_en && full && !flush) begin
            overflow_nxt_s = 1'b1;
        end else if (clr_overflow) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow;
        end
    end

    // Queue bookkeeping registers, with full/empty decoded from the next count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count    <= CNT_ZERO;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count    <= count_nxt_s;
            full     <= (count_nxt_s == CNT_DEPTH);
            empty    <= (count_nxt_s == CNT_ZERO);
            overflow <= overflow_nxt_s;
        end
    end

    // Send sequencer: latch the head byte, hold it until the UART reports the frame done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            tx_enable <= 1'b0;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!empty && !flush) begin
                        tx_data   <= rd_data_s;
                        tx_enable <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (byte_done) begin
                        tx_enable <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    tx_enable <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
